busio_lsu: RTL and testbench

Data-side bus interface directly downstream of the memory stage.
- Consumes the stage's combinational load/store request (address, size, sign, store data).
- Runs a valid/ready request, rvalid response transaction on the data bus.
- Returns aligned, sign/zero-extended load data to the stage's register edge.
- Raises a busy/stall request to the hazard unit while a transaction is outstanding.

---
 rtl/busio_pkg.sv | 21 ++
 rtl/busio_if.sv | 25 ++
 rtl/busio_align.sv | 52 +++++
 rtl/busio_lsu.sv | 185 ++++++++++++++++++
 tb/tb_busio_lsu.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/busio_pkg.sv
// busio_pkg: shared types for the data-bus load/store unit.
// FSM states, access-size encodings and the default timeout.
package busio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_INVALID = 2'b11
  } size_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/busio_if.sv
// busio_if: data-bus request/response bundle.
// Master issues valid/ready requests; slave answers with rvalid.
interface busio_if;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        we;
  logic        valid;
  logic        ready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  modport master (
    output addr, wdata, wstrb, we, valid,
    input  ready, rdata, rvalid, err
  );

  modport slave (
    input  addr, wdata, wstrb, we, valid,
    output ready, rdata, rvalid, err
  );

endinterface

// File: rtl/busio_align.sv
// busio_align: byte-lane steering for the data bus.
// Store strobes/replication and load extraction/extension.
module busio_align
  import busio_pkg::*;
(
  input  size_e       st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_strb_o,
  output logic [31:0] st_wdata_o,
  input  size_e       ld_size_i,
  input  logic        ld_signed_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;

  always_comb begin
    st_strb_o  = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_size_i)
      SIZE_BYTE: begin
        st_strb_o  = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      SIZE_HALF: begin
        st_strb_o  = 4'b0011 << st_off_i;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0 before extending.
  assign shifted = ld_rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    ld_data_o = shifted;
    case (ld_size_i)
      SIZE_BYTE:
        ld_data_o = {{24{ld_signed_i & shifted[7]}},
                     shifted[7:0]};
      SIZE_HALF:
        ld_data_o = {{16{ld_signed_i & shifted[15]}},
                     shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/busio_lsu.sv
// busio_lsu: memory-stage data-bus interface (IDLE/REQ/RESP/DONE).
// Optional BUSIO_TIMEOUT_EN forces a faulted DONE after TIMEOUT_CYCLES.
module busio_lsu
  import busio_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_store_data,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic        stall,
  input  logic        invalidate,
  output logic [31:0] mem_load_data,
  output logic        mem_busy,
  output logic        mem_fault,
  busio_if.master     dbus
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ldata_q, ldata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        we_q, we_d;
  logic        sgn_q, sgn_d;
  logic        fault_q, fault_d;
  logic        disc_q, disc_d;
  size_e       size_q, size_d;
  logic [1:0]  off_q, off_d;

  logic        req;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  assign req = (mem_load | mem_store)
             && (mem_size != SIZE_INVALID)
             && !invalidate;

  busio_align u_align (
    .st_size_i   (size_e'(mem_size)),
    .st_off_i    (mem_address[1:0]),
    .st_data_i   (mem_store_data),
    .st_strb_o   (st_strb),
    .st_wdata_o  (st_wdata),
    .ld_size_i   (size_q),
    .ld_signed_i (sgn_q),
    .ld_off_i    (off_q),
    .ld_rdata_i  (dbus.rdata),
    .ld_data_o   (ld_data)
  );

`ifdef BUSIO_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo;

  assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE)
      cnt_d = '0;
    else if (state_q == REQ || state_q == RESP)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    we_d    = we_q;
    sgn_d   = sgn_q;
    size_d  = size_q;
    off_d   = off_q;
    ldata_d = ldata_q;
    fault_d = fault_q;
    disc_d  = disc_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = REQ;
          addr_d  = {mem_address[31:2], 2'b00};
          wdata_d = st_wdata;
          wstrb_d = mem_store ? st_strb : 4'b0000;
          we_d    = mem_store;
          sgn_d   = mem_signed;
          size_d  = size_e'(mem_size);
          off_d   = mem_address[1:0];
          disc_d  = 1'b0;
        end
      end
      REQ: begin
        if (invalidate) disc_d = 1'b1;
        if (dbus.ready) state_d = RESP;
      end
      RESP: begin
        if (invalidate) disc_d = 1'b1;
        if (dbus.rvalid) begin
          if (disc_d) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
            ldata_d = (dbus.err || we_q) ? 32'h0 : ld_data;
            fault_d = dbus.err;
          end
        end
      end
      DONE: begin
        if (invalidate || !stall) begin
          state_d = IDLE;
          fault_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef BUSIO_TIMEOUT_EN
    if ((state_q == REQ || state_q == RESP) && tmo) begin
      if (disc_d) begin
        state_d = IDLE;
      end else begin
        state_d = DONE;
        ldata_d = 32'h0;
        fault_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= SIZE_BYTE;
      off_q   <= '0;
      ldata_q <= '0;
      fault_q <= 1'b0;
      disc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      we_q    <= we_d;
      sgn_q   <= sgn_d;
      size_q  <= size_d;
      off_q   <= off_d;
      ldata_q <= ldata_d;
      fault_q <= fault_d;
      disc_q  <= disc_d;
    end
  end

  assign mem_busy = (state_q == IDLE && req)
                 || (state_q == REQ)
                 || (state_q == RESP);

  assign mem_load_data = ldata_q;
  assign mem_fault     = fault_q;

  assign dbus.valid = (state_q == REQ);
  assign dbus.addr  = addr_q;
  assign dbus.wdata = wdata_q;
  assign dbus.wstrb = wstrb_q;
  assign dbus.we    = we_q;

endmodule

// File: tb/tb_busio_lsu.sv
// tb_busio_lsu: directed accesses against a lane-level reference
// model of the access rules, checked every cycle at negedge.
module tb_busio_lsu;
  import busio_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_address;
  logic [31:0] mem_store_data;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic        mem_load;
  logic        mem_store;
  logic        stall;
  logic        invalidate;
  logic [31:0] mem_load_data;
  logic        mem_busy;
  logic        mem_fault;

  busio_if dbus ();

  always #5 clk = ~clk;

  busio_lsu #(.TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_address    (mem_address),
    .mem_store_data (mem_store_data),
    .mem_size       (mem_size),
    .mem_signed     (mem_signed),
    .mem_load       (mem_load),
    .mem_store      (mem_store),
    .stall          (stall),
    .invalidate     (invalidate),
    .mem_load_data  (mem_load_data),
    .mem_busy       (mem_busy),
    .mem_fault      (mem_fault),
    .dbus           (dbus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int issues = 0;
  int busy_cnt = 0;
  logic prev_valid = 1'b0;

  logic [31:0] m_addr, m_wdata, m_ld, last_ld;
  logic [3:0]  m_strb;
  logic        m_we, m_busy, m_valid, m_done, m_fault;
  logic [31:0] got_addr, got_wdata, got_ld;
  logic [3:0]  got_strb;
  logic        got_we, got_fault;

  task automatic cmp(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] ref_strb(input logic [31:0] a,
                                          input logic [1:0] sz);
    logic [3:0] s;
    int n, o;
    n = nbytes(sz);
    o = int'(a[1:0]);
    for (int k = 0; k < 4; k++) s[k] = (k >= o) && (k < o + n);
    return s;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d,
                                            input logic [1:0] sz);
    logic [31:0] w;
    int n;
    n = nbytes(sz);
    for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd,
                                           input logic [31:0] a,
                                           input logic [1:0] sz,
                                           input logic sg);
    longint v;
    int n, o;
    v = 0;
    n = nbytes(sz);
    o = int'(a[1:0]);
    for (int k = 0; k < n; k++)
      v += longint'(rd[8*(o+k) +: 8]) << (8*k);
    if (sg && v >= (longint'(1) << (8*n - 1)))
      v -= (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      cmp("busy", 32'(mem_busy), 32'(m_busy));
      cmp("valid", 32'(dbus.valid), 32'(m_valid));
      if (m_valid) begin
        cmp("addr", dbus.addr, m_addr);
        cmp("wstrb", 32'(dbus.wstrb), 32'(m_strb));
        cmp("we", 32'(dbus.we), 32'(m_we));
        if (m_we) cmp("wdata", dbus.wdata, m_wdata);
      end
      cmp("fault", 32'(mem_fault), 32'(m_done & m_fault));
      if (m_done) cmp("ldata", mem_load_data, m_ld);
      if (dbus.valid && !prev_valid) issues++;
      if (mem_busy) busy_cnt++;
    end
    prev_valid = dbus.valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] a, d,
                         input logic [1:0] sz,
                         input logic sg, st);
    m_addr  = {a[31:2], 2'b00};
    m_we    = st;
    m_strb  = st ? ref_strb(a, sz) : 4'b0000;
    m_wdata = ref_wdata(d, sz);
    issues   = 0;
    busy_cnt = 0;
    mem_address    = a;
    mem_store_data = d;
    mem_size       = sz;
    mem_signed     = sg;
    mem_load       = !st;
    mem_store      = st;
    stall          = 1'b0;
    m_busy  = 1'b1;
    m_valid = 1'b0;
    m_done  = 1'b0;
  endtask

  task automatic access(input logic [31:0] a, d,
                        input logic [1:0] sz,
                        input logic sg, st,
                        input int rw, sw,
                        input logic [31:0] rd,
                        input logic er,
                        input int hold);
    m_ld    = (st || er) ? 32'h0 : ref_load(rd, a, sz, sg);
    m_fault = er;
    present(a, d, sz, sg, st);
    tick();
    m_valid   = 1'b1;
    got_addr  = dbus.addr;
    got_wdata = dbus.wdata;
    got_strb  = dbus.wstrb;
    got_we    = dbus.we;
    repeat (rw) tick();
    dbus.ready = 1'b1;
    tick();
    dbus.ready = 1'b0;
    m_valid    = 1'b0;
    repeat (sw) tick();
    dbus.rvalid = 1'b1;
    dbus.rdata  = rd;
    dbus.err    = er;
    tick();
    dbus.rvalid = 1'b0;
    dbus.err    = 1'b0;
    dbus.rdata  = ~rd;
    m_busy = 1'b0;
    m_done = 1'b1;
    got_ld    = mem_load_data;
    got_fault = mem_fault;
    stall = 1'b1;
    repeat (hold) tick();
    stall = 1'b0;
    tick();
    mem_load  = 1'b0;
    mem_store = 1'b0;
    m_done    = 1'b0;
    last_ld   = m_ld;
    cmp("issues", issues, 1);
    cmp("busy_cycles", busy_cnt, rw + sw + 3);
  endtask

  initial begin
    rst_n = 1'b0;
    mem_address = '0;
    mem_store_data = '0;
    mem_size = 2'b00;
    mem_signed = 1'b0;
    mem_load = 1'b0;
    mem_store = 1'b0;
    stall = 1'b0;
    invalidate = 1'b0;
    dbus.ready = 1'b0;
    dbus.rdata = '0;
    dbus.rvalid = 1'b0;
    dbus.err = 1'b0;
    m_addr = '0; m_wdata = '0; m_ld = '0; last_ld = '0;
    m_strb = '0; m_we = 1'b0; m_busy = 1'b0;
    m_valid = 1'b0; m_done = 1'b0; m_fault = 1'b0;

    repeat (2) tick();
    cmp("rst_valid", 32'(dbus.valid), 0);
    cmp("rst_addr", dbus.addr, 0);
    cmp("rst_wdata", dbus.wdata, 0);
    cmp("rst_wstrb", 32'(dbus.wstrb), 0);
    cmp("rst_we", 32'(dbus.we), 0);
    cmp("rst_ldata", mem_load_data, 0);
    cmp("rst_fault", 32'(mem_fault), 0);
    cmp("rst_busy", 32'(mem_busy), 0);
    rst_n = 1'b1;
    tick();

    cmp("lit_strb_b3", 32'(ref_strb(32'h1003, 2'b00)), 32'h8);
    cmp("lit_wdata_b", ref_wdata(32'hAB, 2'b00), 32'hABABABAB);
    cmp("lit_strb_h2", 32'(ref_strb(32'h4002, 2'b01)), 32'hC);
    cmp("lit_ld_hs",
        ref_load(32'h80011234, 32'h2002, 2'b01, 1'b1), 32'hFFFF8001);
    cmp("lit_ld_hu",
        ref_load(32'h80011234, 32'h2002, 2'b01, 1'b0), 32'h00008001);

    access(32'h1003, 32'hAB, 2'b00, 1'b0, 1'b1, 0, 0, 0, 1'b0, 0);
    cmp("sb_addr", got_addr, 32'h1000);
    cmp("sb_strb", 32'(got_strb), 32'h8);
    cmp("sb_wdata", got_wdata, 32'hABABABAB);
    cmp("sb_we", 32'(got_we), 1);

    access(32'h2002, 0, 2'b01, 1'b1, 1'b0, 0, 0,
           32'h80011234, 1'b0, 0);
    cmp("lh_signed", got_ld, 32'hFFFF8001);
    access(32'h2002, 0, 2'b01, 1'b0, 1'b0, 0, 0,
           32'h80011234, 1'b0, 0);
    cmp("lh_unsigned", got_ld, 32'h00008001);

    access(32'h3000, 0, 2'b10, 1'b0, 1'b0, 5, 0,
           32'hCAFEF00D, 1'b0, 0);
    cmp("lw_wait", got_ld, 32'hCAFEF00D);
    access(32'h3001, 0, 2'b00, 1'b1, 1'b0, 0, 1,
           32'h00008000, 1'b0, 4);
    cmp("lb_stall", got_ld, 32'hFFFFFF80);

    access(32'h4002, 32'h12345678, 2'b01, 1'b0, 1'b1, 1, 2,
           0, 1'b0, 1);
    cmp("sh_strb", 32'(got_strb), 32'hC);
    cmp("sh_wdata", got_wdata, 32'h56785678);
    access(32'h5000, 32'hDEADBEEF, 2'b10, 1'b0, 1'b1, 0, 3,
           0, 1'b0, 0);
    access(32'h6003, 0, 2'b00, 1'b0, 1'b0, 0, 0,
           32'hF1000000, 1'b0, 0);
    cmp("lbu", got_ld, 32'h000000F1);

    m_fault = 1'b0;
    present(32'h8000, 0, 2'b10, 1'b0, 1'b0);
    tick();
    m_valid = 1'b1;
    dbus.ready = 1'b1;
    tick();
    dbus.ready = 1'b0;
    m_valid = 1'b0;
    invalidate = 1'b1;
    mem_load = 1'b0;
    tick();
    invalidate = 1'b0;
    dbus.rvalid = 1'b1;
    dbus.rdata = 32'h5555AAAA;
    dbus.err = 1'b1;
    tick();
    dbus.rvalid = 1'b0;
    dbus.err = 1'b0;
    m_busy = 1'b0;
    tick();
    cmp("disc_ldata", mem_load_data, last_ld);
    cmp("disc_issues", issues, 1);

    access(32'h6000, 0, 2'b10, 1'b0, 1'b0, 0, 0,
           32'h12345678, 1'b1, 2);
    cmp("err_fault", 32'(got_fault), 1);
    cmp("err_ldata", got_ld, 0);

    issues = 0;
    m_busy = 1'b0;
    m_valid = 1'b0;
    mem_load = 1'b1;
    mem_size = 2'b11;
    tick();
    tick();
    mem_size = 2'b10;
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    mem_load = 1'b0;
    dbus.rvalid = 1'b1;
    dbus.err = 1'b1;
    tick();
    dbus.rvalid = 1'b0;
    dbus.err = 1'b0;
    tick();
    cmp("noreq_issues", issues, 0);

    access(32'h7001, 0, 2'b00, 1'b0, 1'b0, 0, 0,
           32'h00003C00, 1'b0, 0);
    cmp("lbu_after", got_ld, 32'h0000003C);

    present(32'h9000, 0, 2'b10, 1'b0, 1'b0);
    tick();
    m_valid = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    mem_load = 1'b0;
    m_valid = 1'b0;
    m_busy = 1'b0;
    #1;
    cmp("rst_async_valid", 32'(dbus.valid), 0);
    cmp("rst_async_busy", 32'(mem_busy), 0);
    tick();
    rst_n = 1'b1;
    last_ld = '0;
    tick();

    access(32'hA002, 32'h0000BEEF, 2'b01, 1'b0, 1'b1, 0, 0,
           0, 1'b0, 0);
    cmp("sh_after_rst", got_wdata, 32'hBEEFBEEF);

`ifdef BUSIO_TIMEOUT_EN
    present(32'hB000, 0, 2'b10, 1'b0, 1'b0);
    tick();
    m_valid = 1'b1;
    repeat (8) tick();
    m_valid = 1'b0;
    m_busy = 1'b0;
    m_done = 1'b1;
    m_ld = 32'h0;
    m_fault = 1'b1;
    cmp("tmo_valid", 32'(dbus.valid), 0);
    cmp("tmo_fault", 32'(mem_fault), 1);
    cmp("tmo_ldata", mem_load_data, 0);
    tick();
    mem_load = 1'b0;
    m_done = 1'b0;
    dbus.rvalid = 1'b1;
    dbus.rdata = 32'hFFFFFFFF;
    tick();
    dbus.rvalid = 1'b0;
    tick();
    cmp("tmo_issues", issues, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
